param_step_counter: RTL and testbench



---
 rtl/param_step_counter.sv | 124 ++++++++++++
 tb/tb_param_step_counter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/param_step_counter.sv
// Bank of CHANNELS independent step counters with clear/load/enable priority, wrap or saturate, tc pulse.
// Optional sticky overflow flags when PARAM_STEP_COUNTER_OVF_STICKY_EN is defined.

module param_step_counter_lane #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH:0]   MAX_X    = '1,
  parameter logic [WIDTH:0]   STEP_X   = 1,
  parameter logic [WIDTH-1:0] RST_W    = '0,
  parameter bit               SATURATE = 1'b0
) (
  input  logic             ck,
  input  logic             arst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] ld_i,
`ifdef PARAM_STEP_COUNTER_OVF_STICKY_EN
  input  logic             ovf_clr_i,
  output logic             ovf_o,
`endif
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o
);
  localparam logic [WIDTH-1:0] MAX_W = MAX_X[WIDTH-1:0];
  localparam logic [WIDTH:0]   MOD_X = MAX_X + 1'b1;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic [WIDTH:0]   sum;
  logic             ovf;

  // Sum is one bit wider than the counter so overflow past 2**WIDTH-1 is still visible.
  always_comb begin
    sum   = {1'b0, cnt_q} + STEP_X;
    ovf   = (sum > MAX_X);
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (clr_i) begin
      cnt_d = RST_W;
    end else if (load_i) begin
      cnt_d = (ld_i > MAX_W) ? MAX_W : ld_i;
    end else if (en_i) begin
      tc_d = ovf;
      if (!ovf)          cnt_d = sum[WIDTH-1:0];
      else if (SATURATE) cnt_d = MAX_W;
      else               cnt_d = WIDTH'(sum - MOD_X);
    end
  end

  always_ff @(posedge ck or negedge arst) begin
    if (!arst) begin
      cnt_q <= RST_W;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = tc_q;

`ifdef PARAM_STEP_COUNTER_OVF_STICKY_EN
  logic ovf_q, ovf_d;

  // A new terminal count beats a coincident clear.
  always_comb ovf_d = tc_d | (ovf_q & ~ovf_clr_i);

  always_ff @(posedge ck or negedge arst) begin
    if (!arst) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf_o = ovf_q;
`endif
endmodule

module param_step_counter #(
  parameter int unsigned     WIDTH       = 32,
  parameter int unsigned     CHANNELS    = 4,
  parameter longint unsigned STEP        = 1,
  parameter longint unsigned MAX_VALUE   = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SATURATE    = 1'b0,
  parameter longint unsigned RESET_VALUE = 0
) (
  input  logic                      ck,
  input  logic                      arst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       clr,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_value,
`ifdef PARAM_STEP_COUNTER_OVF_STICKY_EN
  input  logic [CHANNELS-1:0]       ovf_clr,
  output logic [CHANNELS-1:0]       ovf,
`endif
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       tc
);
  localparam logic [WIDTH:0]   MAX_X  = MAX_VALUE[WIDTH:0];
  localparam logic [WIDTH:0]   STEP_X = STEP[WIDTH:0];
  localparam logic [WIDTH-1:0] RST_W  = RESET_VALUE[WIDTH-1:0];

  // Instance array slices the packed buses: lane i owns bits [i*WIDTH +: WIDTH].
  param_step_counter_lane #(
    .WIDTH    (WIDTH),
    .MAX_X    (MAX_X),
    .STEP_X   (STEP_X),
    .RST_W    (RST_W),
    .SATURATE (SATURATE)
  ) u_lane [CHANNELS-1:0] (
    .ck        (ck),
    .arst      (arst),
    .en_i      (en),
    .clr_i     (clr),
    .load_i    (load),
    .ld_i      (load_value),
`ifdef PARAM_STEP_COUNTER_OVF_STICKY_EN
    .ovf_clr_i (ovf_clr),
    .ovf_o     (ovf),
`endif
    .cnt_o     (count),
    .tc_o      (tc)
  );
endmodule

// File: tb/tb_param_step_counter.sv
// Bench for param_step_counter: 4-bit wrap/saturate banks (MAX 9, STEP 3, reset 5) and a default 32-bit bank.
module tb_param_step_counter;
  logic ck = 1'b0;
  logic arst;

  logic [3:0]   en_a, clr_a, load_a;
  logic [15:0]  lv_a, cnt_w, cnt_s;
  logic [3:0]   tc_w, tc_s;
  logic [3:0]   en_b, clr_b, load_b;
  logic [127:0] lv_b, cnt_b;
  logic [3:0]   tc_b;
`ifdef PARAM_STEP_COUNTER_OVF_STICKY_EN
  logic [3:0] ovfc_a, ovfc_b, ovf_w, ovf_s, ovf_b;
  logic [3:0] om_w, om_s;
`endif

  always #5 ck = ~ck;

  param_step_counter #(.WIDTH(4), .CHANNELS(4), .STEP(3), .MAX_VALUE(9), .SATURATE(1'b0), .RESET_VALUE(5)) u_wrap (
    .ck(ck), .arst(arst), .en(en_a), .clr(clr_a), .load(load_a), .load_value(lv_a),
`ifdef PARAM_STEP_COUNTER_OVF_STICKY_EN
    .ovf_clr(ovfc_a), .ovf(ovf_w),
`endif
    .count(cnt_w), .tc(tc_w));

  param_step_counter #(.WIDTH(4), .CHANNELS(4), .STEP(3), .MAX_VALUE(9), .SATURATE(1'b1), .RESET_VALUE(5)) u_sat (
    .ck(ck), .arst(arst), .en(en_a), .clr(clr_a), .load(load_a), .load_value(lv_a),
`ifdef PARAM_STEP_COUNTER_OVF_STICKY_EN
    .ovf_clr(ovfc_a), .ovf(ovf_s),
`endif
    .count(cnt_s), .tc(tc_s));

  param_step_counter #(.WIDTH(32), .CHANNELS(4)) u_big (
    .ck(ck), .arst(arst), .en(en_b), .clr(clr_b), .load(load_b), .load_value(lv_b),
`ifdef PARAM_STEP_COUNTER_OVF_STICKY_EN
    .ovf_clr(ovfc_b), .ovf(ovf_b),
`endif
    .count(cnt_b), .tc(tc_b));

  typedef struct {
    logic [3:0]  en, clr, load;
    logic [15:0] lv, cw;
    logic [3:0]  tw;
    logic [15:0] cs;
    logic [3:0]  ts;
  } vec_t;

  typedef struct {
    logic [127:0] c;
    logic [3:0]   t;
  } exp_b_t;

  vec_t   q_a[$];
  exp_b_t q_b[$];
  vec_t   tbl[16];
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic run_a(input vec_t v, input string nm);
    vec_t e;
    en_a = v.en; clr_a = v.clr; load_a = v.load; lv_a = v.lv;
    q_a.push_back(v);
    tick();
    e = q_a.pop_front();
    chk({nm, " count wrap"}, 128'(cnt_w), 128'(e.cw));
    chk({nm, " tc wrap"},    128'(tc_w),  128'(e.tw));
    chk({nm, " count sat"},  128'(cnt_s), 128'(e.cs));
    chk({nm, " tc sat"},     128'(tc_s),  128'(e.ts));
`ifdef PARAM_STEP_COUNTER_OVF_STICKY_EN
    om_w = e.tw | (om_w & ~ovfc_a);
    om_s = e.ts | (om_s & ~ovfc_a);
    chk({nm, " ovf wrap"}, 128'(ovf_w), 128'(om_w));
    chk({nm, " ovf sat"},  128'(ovf_s), 128'(om_s));
`endif
  endtask

  task automatic run_b(input logic [3:0] en, input logic [3:0] clr, input logic [3:0] ld,
                       input logic [127:0] lv, input logic [127:0] ec, input logic [3:0] et,
                       input string nm);
    exp_b_t e;
    en_b = en; clr_b = clr; load_b = ld; lv_b = lv;
    e.c = ec; e.t = et;
    q_b.push_back(e);
    tick();
    e = q_b.pop_front();
    chk({nm, " count"}, cnt_b, e.c);
    chk({nm, " tc"},    128'(tc_b), 128'(e.t));
  endtask

  initial begin
    // {en, clr, load, load_value, count wrap, tc wrap, count sat, tc sat}; nibble i = channel i
    tbl[0]  = '{4'h0, 4'h0, 4'hF, 16'h0000, 16'h0000, 4'h0, 16'h0000, 4'h0};
    tbl[1]  = '{4'hF, 4'h0, 4'h0, 16'h0000, 16'h3333, 4'h0, 16'h3333, 4'h0};
    tbl[2]  = '{4'hF, 4'h0, 4'h0, 16'h0000, 16'h6666, 4'h0, 16'h6666, 4'h0};
    tbl[3]  = '{4'hF, 4'h0, 4'h0, 16'h0000, 16'h9999, 4'h0, 16'h9999, 4'h0};
    tbl[4]  = '{4'hF, 4'h0, 4'h0, 16'h0000, 16'h2222, 4'hF, 16'h9999, 4'hF};
    tbl[5]  = '{4'hF, 4'h0, 4'h0, 16'h0000, 16'h5555, 4'h0, 16'h9999, 4'hF};
    tbl[6]  = '{4'h0, 4'h0, 4'h0, 16'h0000, 16'h5555, 4'h0, 16'h9999, 4'h0};
    tbl[7]  = '{4'hF, 4'hF, 4'hF, 16'h7777, 16'h5555, 4'h0, 16'h5555, 4'h0};
    tbl[8]  = '{4'hF, 4'h0, 4'hF, 16'h7777, 16'h7777, 4'h0, 16'h7777, 4'h0};
    tbl[9]  = '{4'h0, 4'h0, 4'hF, 16'hFFFF, 16'h9999, 4'h0, 16'h9999, 4'h0};
    tbl[10] = '{4'h5, 4'h0, 4'h0, 16'h0000, 16'h9292, 4'h5, 16'h9999, 4'h5};
    tbl[11] = '{4'hC, 4'h1, 4'h2, 16'h0040, 16'h2545, 4'h8, 16'h9945, 4'hC};
    tbl[12] = '{4'h0, 4'h0, 4'h0, 16'h0000, 16'h2545, 4'h0, 16'h9945, 4'h0};
    tbl[13] = '{4'h0, 4'h0, 4'hF, 16'h8888, 16'h8888, 4'h0, 16'h8888, 4'h0};
    tbl[14] = '{4'hF, 4'h0, 4'h0, 16'h0000, 16'h1111, 4'hF, 16'h9999, 4'hF};
    tbl[15] = '{4'hA, 4'h0, 4'h5, 16'h0000, 16'h4040, 4'h0, 16'h9090, 4'hA};

    arst = 1'b0;
    en_a = '0; clr_a = '0; load_a = '0; lv_a = '0;
    en_b = '0; clr_b = '0; load_b = '0; lv_b = '0;
`ifdef PARAM_STEP_COUNTER_OVF_STICKY_EN
    ovfc_a = '0; ovfc_b = '0; om_w = '0; om_s = '0;
`endif
    tick(); tick();
    chk("reset count wrap", 128'(cnt_w), 128'h5555);
    chk("reset count sat",  128'(cnt_s), 128'h5555);
    chk("reset tc",         128'({tc_w, tc_s, tc_b}), 128'h0);
    chk("reset count big",  cnt_b, 128'h0);
`ifdef PARAM_STEP_COUNTER_OVF_STICKY_EN
    chk("reset ovf", 128'({ovf_w, ovf_s, ovf_b}), 128'h0);
`endif

    // Move away from reset values, then pull arst mid-cycle with activity pending.
    arst = 1'b1;
    load_a = 4'hF; lv_a = 16'h0000; load_b = 4'h1; lv_b = 128'h1234;
    tick();
    chk("pre-reset load wrap", 128'(cnt_w), 128'h0000);
    chk("pre-reset load big",  cnt_b, 128'h1234);
    load_a = '0; en_a = 4'hF; en_b = 4'hF; load_b = '0;
    #3 arst = 1'b0;
    #1;
    chk("async reset count wrap", 128'(cnt_w), 128'h5555);
    chk("async reset count sat",  128'(cnt_s), 128'h5555);
    chk("async reset count big",  cnt_b, 128'h0);
    chk("async reset tc",         128'({tc_w, tc_s, tc_b}), 128'h0);
    en_a = '0; en_b = '0;
    arst = 1'b1;
    tick();
    chk("release count wrap", 128'(cnt_w), 128'h5555);
    chk("release count sat",  128'(cnt_s), 128'h5555);
    chk("release count big",  cnt_b, 128'h0);

    for (int i = 0; i < 16; i++) run_a(tbl[i], $sformatf("vec%0d", i));

`ifdef PARAM_STEP_COUNTER_OVF_STICKY_EN
    ovfc_a = 4'hF;
    run_a('{4'h0, 4'h0, 4'h0, 16'h0000, 16'h4040, 4'h0, 16'h9090, 4'h0}, "sticky clr all");
    chk("sticky cleared", 128'({ovf_w, ovf_s}), 128'h00);
    ovfc_a = 4'h0;
    run_a('{4'h0, 4'h0, 4'h2, 16'h0090, 16'h4090, 4'h0, 16'h9090, 4'h0}, "sticky load");
    run_a('{4'h2, 4'h0, 4'h0, 16'h0000, 16'h4020, 4'h2, 16'h9090, 4'h2}, "sticky wrap");
    chk("sticky set", 128'({ovf_w, ovf_s}), 128'h22);
    run_a('{4'h0, 4'h0, 4'h0, 16'h0000, 16'h4020, 4'h0, 16'h9090, 4'h0}, "sticky hold");
    chk("sticky held", 128'({ovf_w, ovf_s}), 128'h22);
    ovfc_a = 4'h2;
    run_a('{4'h0, 4'h0, 4'h0, 16'h0000, 16'h4020, 4'h0, 16'h9090, 4'h0}, "sticky pulse");
    chk("sticky pulse clr", 128'({ovf_w, ovf_s}), 128'h00);
    ovfc_a = 4'h0;
    run_a('{4'h0, 4'h0, 4'h2, 16'h0090, 16'h4090, 4'h0, 16'h9090, 4'h0}, "sticky reload");
    ovfc_a = 4'h2;
    run_a('{4'h2, 4'h0, 4'h0, 16'h0000, 16'h4020, 4'h2, 16'h9090, 4'h2}, "sticky set vs clr");
    chk("sticky set wins", 128'({ovf_w, ovf_s}), 128'h22);
    ovfc_a = 4'h0;
`endif

    // Default 32-bit bank: channel independence and full-width wrap.
    run_b(4'h5, 4'h0, 4'h0, 128'h0, {32'h0, 32'h1, 32'h0, 32'h1}, 4'h0, "indep 1");
    run_b(4'h5, 4'h0, 4'h0, 128'h0, {32'h0, 32'h2, 32'h0, 32'h2}, 4'h0, "indep 2");
    run_b(4'h0, 4'h0, 4'hA, {32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'h0},
          {32'hFFFF_FFFE, 32'h2, 32'hFFFF_FFFF, 32'h2}, 4'h0, "big load");
    run_b(4'hA, 4'h0, 4'h0, 128'h0, {32'hFFFF_FFFF, 32'h2, 32'h0, 32'h2}, 4'h2, "big wrap");
`ifdef PARAM_STEP_COUNTER_OVF_STICKY_EN
    chk("big ovf", 128'(ovf_b), 128'h2);
`endif
    run_b(4'hF, 4'hF, 4'h0, 128'h0, 128'h0, 4'h0, "big clr");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
